gpia_port: RTL

- Parametrised general-purpose I/O port for the Kestrel-3. It generalises the single-bit GPIA output cell to WIDTH bits.
- Output latch supports four write modes: write, set, clear and toggle. Input pins pass through a 2-flop synchroniser. A per-bit edge detector latches events, and a maskable interrupt is raised from those events.
- Sits on the Wishbone bus as a classic single-cycle slave with one wait state. Drives and samples board pins directly.

---
 rtl/gpia_port.sv | 117 +++++++++++
 1 files changed

// File: rtl/gpia_port.sv
// General-purpose I/O port: 4-mode output latch, 2-flop input sync, per-bit edge status, maskable irq.
// Latency: Wishbone access acked 1 clock after request (2 clocks per access); pin->IN 2 clocks, pin->EDGE 3, ->irq 4.
// Backpressure: none beyond the single wait state; a new request is only accepted while ack_o is low.
module gpia_port #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             res_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [2:0]       adr_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             ack_o,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] q_o,
    output logic             irq_o
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_s3;
    logic [WIDTH-1:0] r_sts;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_pol;
    logic [WIDTH-1:0] r_dat;
    logic             r_ack;
    logic             r_irq;
    logic [1:0]       r_settle;

    logic             w_req;
    logic             w_wr;
    logic [WIDTH-1:0] w_ev;
    logic [WIDTH-1:0] w_rd;
    logic [WIDTH-1:0] w_w1c;
    logic [WIDTH-1:0] w_q_nxt;

    always_comb begin
        w_req = cyc_i & stb_i & ~r_ack;
        w_wr  = w_req & we_i;

        // Events are suppressed until the synchroniser has been filled from real pin values.
        w_ev = '0;
        if (r_settle == 2'd3) begin
            w_ev = (r_pol & r_s2 & ~r_s3) | (~r_pol & ~r_s2 & r_s3);
        end

        case (adr_i)
            3'd0, 3'd1, 3'd2, 3'd3: w_rd = r_q;
            3'd4:                   w_rd = r_s2;
            3'd5:                   w_rd = r_sts;
            3'd6:                   w_rd = r_mask;
            default:                w_rd = r_pol;
        endcase

        w_q_nxt = r_q;
        if (w_wr) begin
            case (adr_i)
                3'd0:    w_q_nxt = dat_i;
                3'd1:    w_q_nxt = r_q | dat_i;
                3'd2:    w_q_nxt = r_q & ~dat_i;
                3'd3:    w_q_nxt = r_q ^ dat_i;
                default: w_q_nxt = r_q;
            endcase
        end

        w_w1c = '0;
        if (w_wr && (adr_i == 3'd5)) begin
            w_w1c = dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            r_q      <= '0;
            r_s1     <= '0;
            r_s2     <= '0;
            r_s3     <= '0;
            r_sts    <= '0;
            r_mask   <= '0;
            r_pol    <= '0;
            r_dat    <= '0;
            r_ack    <= 1'b0;
            r_irq    <= 1'b0;
            r_settle <= 2'd0;
        end else begin
            r_s1  <= pin_i;
            r_s2  <= r_s1;
            r_s3  <= r_s2;
            r_q   <= w_q_nxt;
            // A fresh event wins over a simultaneous clear of the same bit.
            r_sts <= (r_sts & ~w_w1c) | w_ev;
            r_irq <= |(r_sts & r_mask);
            r_ack <= w_req;
            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end
            if (w_req) begin
                r_dat <= w_rd;
            end
            if (w_wr && (adr_i == 3'd6)) begin
                r_mask <= dat_i;
            end
            if (w_wr && (adr_i == 3'd7)) begin
                r_pol <= dat_i;
            end
        end
    end

    assign dat_o = r_dat;
    assign ack_o = r_ack;
    assign q_o   = r_q;
    assign irq_o = r_irq;

endmodule
